// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter encodings
// and the policy values used at reset and on allocation.
package bp_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET    = WNT;
    localparam ctr_t ALLOC_BRANCH = WT;
    localparam ctr_t ALLOC_JUMP   = ST;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating branch history counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    input  logic force_strong,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (force_strong) begin
            ctr_next = ST;
        end else begin
            unique case (ctr)
                SNT: ctr_next = taken ? WNT : SNT;
                WNT: ctr_next = taken ? WT  : SNT;
                WT:  ctr_next = taken ? ST  : WNT;
                ST:  ctr_next = taken ? ST  : WT;
                default: ctr_next = ctr;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor_fetch.sv
// Direct-mapped BTB + 2-bit BHT predictor: zero-latency lookup for fetch,
// registered update and misprediction reporting from execute.
module branch_predictor_fetch
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = DEFAULT_XLEN,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredPCF,
    input  logic            UpdateE,
    input  logic            IsJumpE,
    input  logic [XLEN-1:0] PCE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredPCE,
    output logic            MispredictE,
    output logic [XLEN-1:0] CorrectPCE,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredCount
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];
    logic [31:0]        branch_cnt_q;
    logic [31:0]        mispred_cnt_q;

    logic [IDXW-1:0] f_idx;
    logic [IDXW-1:0] e_idx;
    logic [TAGW-1:0] f_tag;
    logic [TAGW-1:0] e_tag;
    logic            f_hit;
    logic            e_hit;
    ctr_t            e_ctr_next;

    assign f_idx = PCF[IDXW+1:2];
    assign f_tag = PCF[XLEN-1:IDXW+2];
    assign e_idx = PCE[IDXW+1:2];
    assign e_tag = PCE[XLEN-1:IDXW+2];

    // Lookup reads the registered table directly, so a same-index update
    // only becomes visible the cycle after it is written.
    always_comb begin
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        PredTakenF = f_hit && ctr_q[f_idx][1];
        PredPCF    = PredTakenF ? target_q[f_idx] : PCF + XLEN'(4);
    end

    always_comb begin
        e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        CorrectPCE  = TakenE ? TargetE : PCE + XLEN'(4);
        MispredictE = UpdateE && ((TakenE != PredTakenE) ||
                                  (TakenE && (TargetE != PredPCE)));
    end

    bp_sat_counter u_sat_counter (
        .ctr          (ctr_q[e_idx]),
        .taken        (TakenE),
        .force_strong (IsJumpE),
        .ctr_next     (e_ctr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (UpdateE) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (MispredictE) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
            if (e_hit) begin
                ctr_q[e_idx] <= e_ctr_next;
                if (TakenE || IsJumpE) begin
                    target_q[e_idx] <= TargetE;
                end
            end else if (TakenE) begin
                // Not-taken misses are never allocated.
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= TargetE;
                ctr_q[e_idx]    <= IsJumpE ? ALLOC_JUMP : ALLOC_BRANCH;
            end
        end
    end

    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_fetch.sv
// Self-checking bench for branch_predictor_fetch: expected outputs are queued
// as each step is driven and popped for comparison once the DUT settles.
module tb_branch_predictor_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF = '0;
    logic        PredTakenF;
    logic [31:0] PredPCF;
    logic        UpdateE = 1'b0;
    logic        IsJumpE = 1'b0;
    logic [31:0] PCE = '0;
    logic        TakenE = 1'b0;
    logic [31:0] TargetE = '0;
    logic        PredTakenE = 1'b0;
    logic [31:0] PredPCE = '0;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;

    typedef struct {
        logic        upd;
        logic        jmp;
        logic        taken;
        logic        pte;
        logic [31:0] pcf;
        logic [31:0] pce;
        logic [31:0] tgt;
        logic [31:0] ppce;
    } stim_t;

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] ppc;
        logic        mp;
        logic [31:0] cpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    branch_predictor_fetch #(.XLEN(32), .ENTRIES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCF          (PCF),
        .PredTakenF   (PredTakenF),
        .PredPCF      (PredPCF),
        .UpdateE      (UpdateE),
        .IsJumpE      (IsJumpE),
        .PCE          (PCE),
        .TakenE       (TakenE),
        .TargetE      (TargetE),
        .PredTakenE   (PredTakenE),
        .PredPCE      (PredPCE),
        .MispredictE  (MispredictE),
        .CorrectPCE   (CorrectPCE),
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle(input logic [31:0] pcf);
        stim_t s;
        s = '{upd: 1'b0, jmp: 1'b0, taken: 1'b0, pte: 1'b0,
              pcf: pcf, pce: 32'h0, tgt: 32'h0, ppce: 32'h0};
        return s;
    endfunction

    function automatic stim_t upd(input logic jmp, input logic [31:0] pcf,
                                  input logic [31:0] pce, input logic taken,
                                  input logic [31:0] tgt, input logic pte,
                                  input logic [31:0] ppce);
        stim_t s;
        s = '{upd: 1'b1, jmp: jmp, taken: taken, pte: pte,
              pcf: pcf, pce: pce, tgt: tgt, ppce: ppce};
        return s;
    endfunction

    function automatic exp_t ex(input string name, input logic pt,
                                input logic [31:0] ppc, input logic mp,
                                input logic [31:0] cpc, input logic [31:0] bc,
                                input logic [31:0] mc);
        exp_t e;
        e = '{name: name, pt: pt, ppc: ppc, mp: mp, cpc: cpc, bc: bc, mc: mc};
        return e;
    endfunction

    task automatic apply(input stim_t s, input exp_t e);
        @(negedge clk);
        PCF        = s.pcf;
        UpdateE    = s.upd;
        IsJumpE    = s.jmp;
        PCE        = s.pce;
        TakenE     = s.taken;
        TargetE    = s.tgt;
        PredTakenE = s.pte;
        PredPCE    = s.ppce;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        st.push_back(idle(32'h100)); xs.push_back(ex("reset_held",  0, 32'h104, 0, 32'h4, 0, 0));
        st.push_back(idle(32'h100)); xs.push_back(ex("reset_after", 0, 32'h104, 0, 32'h4, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            if (i == 1) reset = 1'b0;
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    task automatic test_allocate();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        st.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104));
        xs.push_back(ex("alloc_update", 0, 32'h104, 1, 32'h40, 0, 0));
        st.push_back(idle(32'h100));
        xs.push_back(ex("alloc_lookup", 1, 32'h40, 0, 32'h4, 1, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    task automatic test_hysteresis();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        // counter walks 10 -> 01 -> 00 -> 01 -> 10 -> 11
        st.push_back(upd(0, 32'h100, 32'h100, 0, 32'h0, 1, 32'h40));
        xs.push_back(ex("hyst_nt1", 1, 32'h40, 1, 32'h104, 1, 1));
        st.push_back(upd(0, 32'h100, 32'h100, 0, 32'h0, 0, 32'h104));
        xs.push_back(ex("hyst_nt2", 0, 32'h104, 0, 32'h104, 2, 2));
        st.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104));
        xs.push_back(ex("hyst_t1", 0, 32'h104, 1, 32'h40, 3, 2));
        st.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 0, 32'h104));
        xs.push_back(ex("hyst_t2", 0, 32'h104, 1, 32'h40, 4, 3));
        st.push_back(upd(0, 32'h100, 32'h100, 1, 32'h40, 1, 32'h40));
        xs.push_back(ex("hyst_t3", 1, 32'h40, 0, 32'h40, 5, 4));
        st.push_back(idle(32'h100));
        xs.push_back(ex("hyst_final", 1, 32'h40, 0, 32'h4, 6, 4));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    task automatic test_alias();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        st.push_back(upd(0, 32'h140, 32'h140, 1, 32'h80, 0, 32'h144));
        xs.push_back(ex("alias_replace", 0, 32'h144, 1, 32'h80, 6, 4));
        st.push_back(idle(32'h100));
        xs.push_back(ex("alias_old_tag", 0, 32'h104, 0, 32'h4, 7, 5));
        st.push_back(idle(32'h140));
        xs.push_back(ex("alias_new_tag", 1, 32'h80, 0, 32'h4, 7, 5));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    task automatic test_same_cycle();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        st.push_back(upd(1, 32'h200, 32'h200, 1, 32'h300, 0, 32'h204));
        xs.push_back(ex("same_cycle_write", 0, 32'h204, 1, 32'h300, 7, 5));
        st.push_back(idle(32'h200));
        xs.push_back(ex("same_cycle_next", 1, 32'h300, 0, 32'h4, 8, 6));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        // PCF+4 wraps at the top of the address space
        st.push_back(upd(0, 32'hFFFF_FFFC, 32'h104, 1, 32'h500, 0, 32'h108));
        xs.push_back(ex("b2b_alloc_wrap", 0, 32'h0, 1, 32'h500, 8, 6));
        st.push_back(upd(1, 32'h104, 32'h104, 1, 32'h600, 1, 32'h500));
        xs.push_back(ex("b2b_jump_target_miss", 1, 32'h500, 1, 32'h600, 9, 7));
        st.push_back(upd(0, 32'h104, 32'h104, 1, 32'h600, 1, 32'h600));
        xs.push_back(ex("b2b_saturate", 1, 32'h600, 0, 32'h600, 10, 8));
        st.push_back(upd(0, 32'h104, 32'h104, 0, 32'h0, 1, 32'h600));
        xs.push_back(ex("b2b_not_taken", 1, 32'h600, 1, 32'h108, 11, 8));
        st.push_back(idle(32'h104));
        xs.push_back(ex("b2b_keep_target", 1, 32'h600, 0, 32'h4, 12, 9));
        st.push_back(upd(0, 32'h200, 32'h3C0, 0, 32'h0, 0, 32'h3C4));
        xs.push_back(ex("b2b_nt_miss", 1, 32'h300, 0, 32'h3C4, 12, 9));
        st.push_back(idle(32'h200));
        xs.push_back(ex("b2b_no_alloc", 1, 32'h300, 0, 32'h4, 13, 9));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    task automatic test_async_reset();
        stim_t st[$];
        exp_t  xs[$];
        exp_t  e;
        // reset rises between edges while an update is presented
        st.push_back(upd(0, 32'h104, 32'h208, 1, 32'h700, 0, 32'h20C));
        xs.push_back(ex("async_mid_cycle", 0, 32'h108, 1, 32'h700, 0, 0));
        st.push_back(idle(32'h208));
        xs.push_back(ex("async_discarded", 0, 32'h20C, 0, 32'h4, 0, 0));
        st.push_back(idle(32'h200));
        xs.push_back(ex("async_cleared_200", 0, 32'h204, 0, 32'h4, 0, 0));
        st.push_back(idle(32'h104));
        xs.push_back(ex("async_cleared_104", 0, 32'h108, 0, 32'h4, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], xs[i]);
            if (i == 0) begin
                #2 reset = 1'b1;
            end
            if (i == 1) reset = 1'b0;
            #1;
            e = sb.pop_front();
            checks++; if (PredTakenF !== e.pt)    begin errors++; $display("FAIL %s PredTakenF got %0b expected %0b", e.name, PredTakenF, e.pt); end
            checks++; if (PredPCF !== e.ppc)      begin errors++; $display("FAIL %s PredPCF got %0h expected %0h", e.name, PredPCF, e.ppc); end
            checks++; if (MispredictE !== e.mp)   begin errors++; $display("FAIL %s MispredictE got %0b expected %0b", e.name, MispredictE, e.mp); end
            checks++; if (CorrectPCE !== e.cpc)   begin errors++; $display("FAIL %s CorrectPCE got %0h expected %0h", e.name, CorrectPCE, e.cpc); end
            checks++; if (BranchCount !== e.bc)   begin errors++; $display("FAIL %s BranchCount got %0d expected %0d", e.name, BranchCount, e.bc); end
            checks++; if (MispredCount !== e.mc)  begin errors++; $display("FAIL %s MispredCount got %0d expected %0d", e.name, MispredCount, e.mc); end
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
